// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: WB, MD, decode and register-file write-port signals of the write arbiter
interface rf_write_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        issue_md;
    logic [4:0]  issue_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic        stall_wb;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_conflict;
    modport slave (
        input  wb_we, wb_addr, wb_data, md_valid, md_addr, md_data, issue_md, issue_addr, rs_addr, rt_addr,
        output md_ready, rs_busy, rt_busy, stall_wb, rf_we, rf_waddr, rf_wdata, sb_conflict
    );
    modport master (
        output wb_we, wb_addr, wb_data, md_valid, md_addr, md_data, issue_md, issue_addr, rs_addr, rt_addr,
        input  md_ready, rs_busy, rt_busy, stall_wb, rf_we, rf_waddr, rf_wdata, sb_conflict
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between WB and MD and tracks outstanding MD destinations
module rf_write_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    typedef enum logic {ARB, FORCE} state_t;
    localparam logic [3:0] LAST = 4'(STARVE_MAX - 1);
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] busy;
    logic        wb_ok;
    logic        wb_grant;
    logic        md_grant;
    logic        md_deny;
    logic        conflict;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    // grant selection, write-port mux, scoreboard lookups and conflict detection
    always_comb begin
        wb_ok        = bus.wb_we && bus.wb_addr != 5'd0;
        wb_grant     = state == ARB && wb_ok;
        md_grant     = bus.md_valid && !wb_grant;
        md_deny      = bus.md_valid && !md_grant;
        bus.md_ready = md_grant;
        bus.rf_we    = md_grant ? bus.md_addr != 5'd0 : wb_grant;
        bus.rf_waddr = md_grant ? bus.md_addr : bus.wb_addr;
        bus.rf_wdata = md_grant ? bus.md_data : bus.wb_data;
        bus.rs_busy  = busy[bus.rs_addr];
        bus.rt_busy  = busy[bus.rt_addr];
        set_mask     = (bus.issue_md && bus.issue_addr != 5'd0) ? 32'd1 << bus.issue_addr : 32'd0;
        clr_mask     = md_grant ? 32'd1 << bus.md_addr : 32'd0;
        conflict     = (bus.issue_md && busy[bus.issue_addr])
                    || (wb_grant && busy[bus.wb_addr])
                    || (md_grant && bus.md_addr != 5'd0 && !busy[bus.md_addr]);
    end
    // arbitration FSM, starvation counter, scoreboard bits and registered flags; bit 0 of busy stays clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ARB;
            cnt             <= 4'd0;
            busy            <= 32'd0;
            bus.stall_wb    <= 1'b0;
            bus.sb_conflict <= 1'b0;
        end else begin
            bus.sb_conflict <= conflict;
            busy            <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
            if (state == ARB && md_deny && cnt == LAST) begin
                state        <= FORCE;
                bus.stall_wb <= 1'b1;
                cnt          <= 4'd0;
            end else begin
                state        <= ARB;
                bus.stall_wb <= 1'b0;
                cnt          <= md_deny ? cnt + 4'd1 : 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scenario tasks plus a write-port scoreboard for rf_write_arbiter
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];
    wr_t got;
    rf_write_arbiter_if bus();
    rf_write_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // every register-file write seen out of reset must match the oldest expected write
    always @(negedge clk) begin
        if (reset && bus.rf_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rf_write unexpected got=%0d/%h want=none", bus.rf_waddr, bus.rf_wdata);
            end else begin
                got = exp_q.pop_front();
                if ({bus.rf_waddr, bus.rf_wdata} !== {got.addr, got.data}) begin
                    bad++;
                    $display("FAIL rf_write got=%0d/%h want=%0d/%h", bus.rf_waddr, bus.rf_wdata, got.addr, got.data);
                end
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.md_valid = 0; bus.md_addr = 0; bus.md_data = 0;
        bus.issue_md = 0; bus.issue_addr = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    endtask
    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{a, d});
    endtask
    task automatic test_reset();
        idle();
        #1 reset = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.wb_we = $urandom_range(0, 1) != 0; bus.wb_addr = 5'($urandom_range(0, 31));
            bus.md_valid = $urandom_range(0, 1) != 0; bus.md_addr = 5'($urandom_range(0, 31));
            bus.issue_md = $urandom_range(0, 1) != 0; bus.issue_addr = 5'($urandom_range(0, 31));
            bus.wb_data = $urandom; bus.md_data = $urandom; bus.rs_addr = 5;
            @(negedge clk);
            total++; if (bus.stall_wb !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall_wb); end
            total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b want=0", bus.sb_conflict); end
            total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL reset_rs_busy got=%b want=0", bus.rs_busy); end
        end
        step(); idle();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b want=0", bus.rf_we); end
        total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL reset_md_ready got=%b want=0", bus.md_ready); end
        step(); reset = 1;
        step(); bus.wb_we = 1; bus.wb_addr = 4; bus.wb_data = 32'h0000_0044; expect_wr(4, 32'h0000_0044);
        @(negedge clk);
        total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL post_reset_md_ready got=%b want=0", bus.md_ready); end
        step(); idle();
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL post_reset_conflict got=%b want=0", bus.sb_conflict); end
    endtask
    task automatic test_priority();
        step(); idle();
        bus.wb_we = 1; bus.wb_addr = 8; bus.wb_data = 32'hAAAA_5555;
        bus.md_valid = 1; bus.md_addr = 9; bus.md_data = 32'h9999_0009;
        expect_wr(8, 32'hAAAA_5555);
        @(negedge clk);
        total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL prio_md_ready got=%b want=0", bus.md_ready); end
        total++; if (bus.rf_waddr !== 5'd8) begin bad++; $display("FAIL prio_waddr got=%0d want=8", bus.rf_waddr); end
        step(); bus.wb_we = 0; expect_wr(9, 32'h9999_0009);
        @(negedge clk);
        total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL prio_md_grant got=%b want=1", bus.md_ready); end
        total++; if (bus.rf_waddr !== 5'd9) begin bad++; $display("FAIL prio_md_waddr got=%0d want=9", bus.rf_waddr); end
        step(); idle();
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b1) begin bad++; $display("FAIL prio_md_nonbusy_conflict got=%b want=1", bus.sb_conflict); end
        step();
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL prio_conflict_clear got=%b want=0", bus.sb_conflict); end
    endtask
    task automatic test_starvation();
        step(); idle(); bus.issue_md = 1; bus.issue_addr = 20;
        for (int i = 0; i < 4; i++) begin
            step(); bus.issue_md = 0;
            bus.wb_we = 1; bus.wb_addr = 5'(10 + i); bus.wb_data = 32'h1000 + i;
            bus.md_valid = 1; bus.md_addr = 20; bus.md_data = 32'h2020_2020;
            expect_wr(5'(10 + i), 32'h1000 + i);
            @(negedge clk);
            total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL starve_deny%0d got=%b want=0", i, bus.md_ready); end
            total++; if (bus.stall_wb !== 1'b0) begin bad++; $display("FAIL starve_stall%0d got=%b want=0", i, bus.stall_wb); end
        end
        step(); expect_wr(20, 32'h2020_2020);
        @(negedge clk);
        total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL starve_force_grant got=%b want=1", bus.md_ready); end
        total++; if (bus.stall_wb !== 1'b1) begin bad++; $display("FAIL starve_force_stall got=%b want=1", bus.stall_wb); end
        total++; if (bus.rf_waddr !== 5'd20) begin bad++; $display("FAIL starve_force_waddr got=%0d want=20", bus.rf_waddr); end
        step(); bus.md_valid = 0; expect_wr(13, 32'h1003);
        @(negedge clk);
        total++; if (bus.stall_wb !== 1'b0) begin bad++; $display("FAIL starve_after_stall got=%b want=0", bus.stall_wb); end
        total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL starve_after_ready got=%b want=0", bus.md_ready); end
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL starve_conflict got=%b want=0", bus.sb_conflict); end
        step(); idle();
    endtask
    task automatic test_back_to_back();
        step(); idle(); bus.issue_md = 1; bus.issue_addr = 21;
        for (int i = 0; i < 10; i++) begin
            logic g;
            g = (i % 5) == 4;
            step(); bus.issue_md = 0;
            bus.wb_we = 1; bus.wb_addr = 13; bus.wb_data = 32'h1300 + i;
            bus.md_valid = 1; bus.md_addr = 21; bus.md_data = 32'h2100 + i;
            if (g) expect_wr(21, 32'h2100 + i); else expect_wr(13, 32'h1300 + i);
            @(negedge clk);
            total++; if (bus.md_ready !== g) begin bad++; $display("FAIL b2b_ready%0d got=%b want=%b", i, bus.md_ready, g); end
            total++; if (bus.stall_wb !== g) begin bad++; $display("FAIL b2b_stall%0d got=%b want=%b", i, bus.stall_wb, g); end
        end
        step(); idle();
        step();
    endtask
    task automatic test_scoreboard();
        step(); idle(); bus.issue_md = 1; bus.issue_addr = 12; bus.rs_addr = 12;
        @(negedge clk);
        total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL sb_no_bypass got=%b want=0", bus.rs_busy); end
        step(); bus.issue_md = 0;
        @(negedge clk);
        total++; if (bus.rs_busy !== 1'b1) begin bad++; $display("FAIL sb_set got=%b want=1", bus.rs_busy); end
        step(); bus.md_valid = 1; bus.md_addr = 12; bus.md_data = 32'hC0DE_0012; expect_wr(12, 32'hC0DE_0012);
        @(negedge clk);
        total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL sb_grant got=%b want=1", bus.md_ready); end
        total++; if (bus.rs_busy !== 1'b1) begin bad++; $display("FAIL sb_busy_during_grant got=%b want=1", bus.rs_busy); end
        step(); bus.md_valid = 0;
        @(negedge clk);
        total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL sb_clear got=%b want=0", bus.rs_busy); end
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL sb_clear_conflict got=%b want=0", bus.sb_conflict); end
        step(); bus.issue_md = 1; bus.issue_addr = 12;
        step(); bus.md_valid = 1; bus.md_addr = 12; bus.md_data = 32'hC0DE_0112; expect_wr(12, 32'hC0DE_0112);
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL sb_first_issue_conflict got=%b want=0", bus.sb_conflict); end
        step(); idle(); bus.rs_addr = 12; bus.rt_addr = 12;
        @(negedge clk);
        total++; if (bus.rt_busy !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b want=1", bus.rt_busy); end
        total++; if (bus.sb_conflict !== 1'b1) begin bad++; $display("FAIL sb_reissue_conflict got=%b want=1", bus.sb_conflict); end
        step(); bus.md_valid = 1; bus.md_addr = 12; bus.md_data = 32'hC0DE_0212; expect_wr(12, 32'hC0DE_0212);
        step(); bus.md_valid = 0;
        @(negedge clk);
        total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL sb_final_clear got=%b want=0", bus.rs_busy); end
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL sb_final_conflict got=%b want=0", bus.sb_conflict); end
        step(); idle();
    endtask
    task automatic test_zero();
        step(); idle();
        bus.wb_we = 1; bus.wb_addr = 0; bus.wb_data = 32'h0000_DEAD;
        bus.md_valid = 1; bus.md_addr = 0; bus.md_data = 32'h0000_BEEF;
        @(negedge clk);
        total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL zero_md_grant got=%b want=1", bus.md_ready); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL zero_rf_we got=%b want=0", bus.rf_we); end
        step(); idle(); bus.issue_md = 1; bus.issue_addr = 0;
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL zero_md_conflict got=%b want=0", bus.sb_conflict); end
        step(); idle();
        @(negedge clk);
        total++; if (bus.rs_busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", bus.rs_busy); end
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL zero_issue_conflict got=%b want=0", bus.sb_conflict); end
    endtask
    task automatic test_conflict();
        step(); idle(); bus.issue_md = 1; bus.issue_addr = 7;
        step();
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL cf_first_issue got=%b want=0", bus.sb_conflict); end
        step(); idle(); bus.wb_we = 1; bus.wb_addr = 7; bus.wb_data = 32'h0000_7777; expect_wr(7, 32'h0000_7777);
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b1) begin bad++; $display("FAIL cf_double_issue got=%b want=1", bus.sb_conflict); end
        total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL cf_waw_write got=%b want=1", bus.rf_we); end
        step(); idle();
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b1) begin bad++; $display("FAIL cf_waw got=%b want=1", bus.sb_conflict); end
        step(); bus.md_valid = 1; bus.md_addr = 3; bus.md_data = 32'h0000_3333; expect_wr(3, 32'h0000_3333);
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL cf_gap got=%b want=0", bus.sb_conflict); end
        step(); idle();
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b1) begin bad++; $display("FAIL cf_md_nonbusy got=%b want=1", bus.sb_conflict); end
        step(); bus.md_valid = 1; bus.md_addr = 7; bus.md_data = 32'h0000_7000; expect_wr(7, 32'h0000_7000);
        step(); idle();
        @(negedge clk);
        total++; if (bus.sb_conflict !== 1'b0) begin bad++; $display("FAIL cf_md_busy got=%b want=0", bus.sb_conflict); end
    endtask
    task automatic test_reset_force();
        for (int i = 0; i < 4; i++) begin
            step();
            bus.wb_we = 1; bus.wb_addr = 14; bus.wb_data = 32'h1400 + i;
            bus.md_valid = 1; bus.md_addr = 22; bus.md_data = 32'h2222_0000;
            expect_wr(14, 32'h1400 + i);
        end
        step();
        total++; if (bus.stall_wb !== 1'b1) begin bad++; $display("FAIL rf_force_entry got=%b want=1", bus.stall_wb); end
        reset = 0;
        #1;
        total++; if (bus.stall_wb !== 1'b0) begin bad++; $display("FAIL rf_force_async_drop got=%b want=0", bus.stall_wb); end
        total++; if (bus.md_ready !== 1'b0) begin bad++; $display("FAIL rf_force_discard got=%b want=0", bus.md_ready); end
        step(); idle();
        step(); reset = 1;
        step();
    endtask
    initial begin
        test_reset();
        test_priority();
        test_starvation();
        test_back_to_back();
        test_scoreboard();
        test_zero();
        test_conflict();
        test_reset_force();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_writes got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
